mesh_node_adapter: RTL
======================

MESH_NODE_ADAPTER -- requirements
Module: mesh_node_adapter

Interface
REQ-001 SHALL have parameter PL, default 32, the flit width in bits; flit bit 0 is the valid flag, and an all-zero flit means idle.
REQ-002 SHALL have parameter DEPTH, default 4, the entries per FIFO (power of two, >=2).
REQ-003 SHALL have parameter NODE_ID, default 0, the mesh node index, passed through to node_id.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, all logic on its rising edge
  rst  in  1  reset, synchronous and active-high
  core_flit_out  in  PL  flit from core
  core_ready  out  1  injection FIFO can accept
  core_flit_in  out  PL  flit to core
  core_flit_ready  in  1  core consumes the presented flit
  noc_core_input  in  PL  flit from router local port
  noc_core_output  out  PL  flit to router local port
  noc_available  in  1  router local port accepts this cycle
  core_availability  out  1  ejection FIFO can accept
  drain_req  in  1  request stop-and-drain
  resume  in  1  return to RUN from IDLE
  drain_done  out  1  state is IDLE
  node_id  out  $clog2(DEPTH*0+9)  constant NODE_ID
  stat_inj / stat_ej / stat_drop  out  16 each  statistics counters

Function
REQ-005 The injection FIFO SHALL push core_flit_out when bit 0=1 and core_ready=1; flits presented while core_ready=0 are ignored.
REQ-006 core_ready SHALL be 1 only when state=RUN and the injection FIFO is not full; a pop in the same cycle does not free a slot for a push.
REQ-007 noc_core_output SHALL equal the injection head when the FIFO is non-empty, noc_available=1 and state!=IDLE, and zero otherwise; the head pops in that same cycle.
REQ-008 Injection latency SHALL be 1 cycle minimum: a flit accepted in cycle N can appear on noc_core_output in cycle N+1.
REQ-009 The ejection FIFO SHALL push noc_core_input when bit 0=1 and the FIFO is not full; simultaneous push/pop on a non-full FIFO keeps the count.
REQ-010 A valid flit that arrives while the ejection FIFO is full SHALL be dropped and SHALL increment the drop count.
REQ-011 core_availability SHALL be 1 when the ejection FIFO is not full, in every state.
REQ-012 core_flit_in SHALL equal the ejection head when the FIFO is non-empty, else zero; the head pops when core_flit_ready=1 and the FIFO is non-empty.
REQ-013 FIFO pointers SHALL wrap modulo DEPTH; occupancy uses a $clog2(DEPTH)+1-bit count that never exceeds DEPTH.
REQ-014 The state machine SHALL implement RUN, DRAIN and IDLE: RUN->DRAIN on drain_req; DRAIN->IDLE when the injection FIFO is empty, including the same cycle as the last pop; IDLE->RUN on resume. drain_req is ignored outside RUN and resume is ignored outside IDLE.
REQ-015 If drain_req and resume are both high, drain_req SHALL take priority in RUN and resume SHALL take priority in IDLE.
REQ-016 drain_done SHALL be 1 exactly while state=IDLE.

Reset
REQ-017 rst=1 SHALL empty both FIFOs and set state=RUN and counters=0. On the next cycle core_ready=1, core_availability=1, core_flit_in=0, noc_core_output=0 and drain_done=0.
REQ-018 Reset asserted mid-transfer SHALL discard all buffered flits; no flit appears on any output in the cycle after rst deasserts.

Configuration
REQ-019 With MESH_NODE_STATS_EN defined, stat_inj SHALL count injection pushes, stat_ej SHALL count ejection pushes and stat_drop SHALL count drops; each counter is 16-bit saturating at 16'hFFFF.
REQ-020 Without MESH_NODE_STATS_EN, the counter logic SHALL be absent and stat_inj, stat_ej and stat_drop SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-021 Reset, then core sends 3 valid flits with noc_available=1 -> the 3 flits appear in order on noc_core_output in cycles 1-3 after each push; stat_inj=3.
REQ-022 With noc_available=0 and DEPTH=4, the core sends 5 flits -> core_ready falls after the 4th push and the 5th is ignored; raising noc_available drains exactly 4 flits.
REQ-023 With core_flit_ready=0, the NoC sends 5 valid flits -> core_availability=0 after 4; the 5th is dropped and stat_drop=1 (0 without the macro); core_flit_in shows the first flit.
REQ-024 Two flits queued, noc_available=0, pulse drain_req -> core_ready=0 immediately. Enable noc_available: the flits leave, drain_done=1 the cycle after the last pop; pulse resume -> RUN, core_ready=1.
REQ-025 drain_req and resume high together in RUN -> state goes to DRAIN; in IDLE -> state goes to RUN.
REQ-026 Assert rst with both FIFOs holding 2 flits -> after release, all outputs are zero, core_ready=1 and the counters are 0.

Source files
------------

// File: rtl/mesh_node_adapter.sv
// mesh_node_adapter: core <-> mesh router local-port adapter, injection/ejection FIFOs plus RUN/DRAIN/IDLE control.
// Latency: 1 cycle core->router (flit registered in the injection FIFO); an ejected flit is visible to the core the cycle after arrival.
// Backpressure: core_ready/core_availability drop when a FIFO is full; a valid flit arriving at a full ejection FIFO is dropped.
// Optional feature: define MESH_NODE_STATS_EN to build the saturating stat_inj/stat_ej/stat_drop counters (tied to 0 otherwise).

// Generic synchronous FIFO: head is combinational, push ignored when full, pop ignored when empty.
module mesh_node_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy 0..DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: reads are qualified by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module mesh_node_adapter #(
   parameter int PL      = 32,
   parameter int DEPTH   = 4,
   parameter int NODE_ID = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PL-1:0]                 core_flit_out,
   output logic                          core_ready,
   output logic [PL-1:0]                 core_flit_in,
   input  logic                          core_flit_ready,
   input  logic [PL-1:0]                 noc_core_input,
   output logic [PL-1:0]                 noc_core_output,
   input  logic                          noc_available,
   output logic                          core_availability,
   input  logic                          drain_req,
   input  logic                          resume,
   output logic                          drain_done,
   output logic [$clog2(DEPTH*0+9)-1:0]  node_id,
   output logic [15:0]                   stat_inj,
   output logic [15:0]                   stat_ej,
   output logic [15:0]                   stat_drop
);
   localparam int AW  = $clog2(DEPTH);
   localparam int NIW = $clog2(DEPTH*0+9);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [PL-1:0] inj_head;
   logic [AW:0]   inj_count;
   logic          inj_empty;
   logic          inj_full;
   logic          inj_push;
   logic          inj_pop;

   logic [PL-1:0] ej_head;
   logic [AW:0]   ej_count;
   logic          ej_empty;
   logic          ej_full;
   logic          ej_push;
   logic          ej_pop;

   assign inj_empty = (inj_count == '0);
   assign inj_full  = (inj_count == CNT_FULL);
   assign ej_empty  = (ej_count == '0);
   assign ej_full   = (ej_count == CNT_FULL);

   assign node_id   = NIW'(NODE_ID);

   // Injection side: core -> FIFO -> router local port.
   mesh_node_fifo #(.W(PL), .DEPTH(DEPTH)) u_inj_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inj_push),
      .push_dat (core_flit_out),
      .pop      (inj_pop),
      .head_dat (inj_head),
      .count    (inj_count)
   );

   // Ejection side: router local port -> FIFO -> core.
   mesh_node_fifo #(.W(PL), .DEPTH(DEPTH)) u_ej_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (ej_push),
      .push_dat (noc_core_input),
      .pop      (ej_pop),
      .head_dat (ej_head),
      .count    (ej_count)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next state and flow-control outputs; core_ready uses the registered full flag so a same-cycle pop never frees a slot.
   always_comb begin
      state_nxt         = state;
      core_ready        = 1'b0;
      inj_push          = 1'b0;
      inj_pop           = 1'b0;
      noc_core_output   = '0;
      ej_push           = 1'b0;
      ej_pop            = 1'b0;
      core_flit_in      = '0;
      core_availability = !ej_full;
      drain_done        = (state == ST_IDLE);

      core_ready = (state == ST_RUN) && !inj_full;
      inj_push   = core_flit_out[0] && core_ready;
      inj_pop    = !inj_empty && noc_available && (state != ST_IDLE);
      if (inj_pop) noc_core_output = inj_head;

      ej_push = noc_core_input[0] && !ej_full;
      ej_pop  = core_flit_ready && !ej_empty;
      if (!ej_empty) core_flit_in = ej_head;

      case (state)
         ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (inj_empty || (inj_pop && inj_count == CNT_ONE)) state_nxt = ST_IDLE;
         ST_IDLE:  if (resume) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

`ifdef MESH_NODE_STATS_EN
   logic [15:0] inj_cnt;
   logic [15:0] ej_cnt;
   logic [15:0] drop_cnt;
   logic        ej_drop;

   assign ej_drop   = noc_core_input[0] && ej_full;
   assign stat_inj  = inj_cnt;
   assign stat_ej   = ej_cnt;
   assign stat_drop = drop_cnt;

   // Saturating event counters; they hold at 16'hFFFF rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         inj_cnt  <= '0;
         ej_cnt   <= '0;
         drop_cnt <= '0;
      end else begin
         if (inj_push && inj_cnt != 16'hFFFF)  inj_cnt  <= inj_cnt + 16'd1;
         if (ej_push && ej_cnt != 16'hFFFF)    ej_cnt   <= ej_cnt + 16'd1;
         if (ej_drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
      end
   end
`else
   assign stat_inj  = 16'd0;
   assign stat_ej   = 16'd0;
   assign stat_drop = 16'd0;
`endif

endmodule
